// File: rtl/weight_loader.sv
// Streams NUM_REGS weights into a register bank, one active-low load strobe per accepted beat,
// then pulses done one cycle after the last register has been strobed.
module weight_loader #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int NUM_REGS      = 9,
    parameter int CNT_WIDTH     = 4
) (
    input  logic                     weight_loader_CLOCK,
    input  logic                     weight_loader_Reset_InHigh,
    input  logic                     weight_loader_Start_InHigh,
    input  logic                     weight_loader_Abort_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] weight_loader_DataInBUS,
    input  logic                     weight_loader_Valid_InHigh,
    output logic                     weight_loader_Ready_OutHigh,
    output logic [DATAWIDTH_BUS-1:0] weight_loader_DataOutBUS,
    output logic [NUM_REGS-1:0]      weight_loader_Load_OutLow,
    output logic [CNT_WIDTH-1:0]     weight_loader_Index_Out,
    output logic                     weight_loader_Busy_OutHigh,
    output logic                     weight_loader_Done_OutHigh
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(NUM_REGS - 1);
    localparam logic [NUM_REGS-1:0]  LP_ONES = '1;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_done;
    logic [NUM_REGS-1:0]      r_load_n;
    logic [DATAWIDTH_BUS-1:0] r_data;
    logic [CNT_WIDTH-1:0]     r_index;

    logic [CNT_WIDTH-1:0]     w_index_nxt;
    logic [DATAWIDTH_BUS-1:0] w_data_nxt;
    logic [NUM_REGS-1:0]      w_load_nxt;
    logic                     w_done_nxt;

    // Strobes default to inactive every cycle, so a bit can only be low for the single
    // cycle following its accepted beat.
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_data_nxt  = r_data;
        w_load_nxt  = LP_ONES;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (weight_loader_Start_InHigh) begin
                    w_state_nxt = S_LOAD;
                    w_index_nxt = '0;
                end
            end
            S_LOAD: begin
                if (weight_loader_Abort_InHigh) begin
                    w_state_nxt = S_IDLE;
                end else if (weight_loader_Valid_InHigh) begin
                    w_data_nxt  = weight_loader_DataInBUS;
                    w_load_nxt  = ~(NUM_REGS'(1) << r_index);
                    w_index_nxt = r_index + CNT_WIDTH'(1);
                    if (r_index == LP_LAST) begin
                        w_state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = ~weight_loader_Abort_InHigh;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Ready/Busy are registered from the next state so they line up with the state they describe.
    always_ff @(posedge weight_loader_CLOCK or posedge weight_loader_Reset_InHigh) begin
        if (weight_loader_Reset_InHigh) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_load_n <= LP_ONES;
            r_data   <= '0;
            r_index  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= (w_state_nxt == S_LOAD);
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= w_done_nxt;
            r_load_n <= w_load_nxt;
            r_data   <= w_data_nxt;
            r_index  <= w_index_nxt;
        end
    end

    assign weight_loader_Ready_OutHigh = r_ready;
    assign weight_loader_DataOutBUS    = r_data;
    assign weight_loader_Load_OutLow   = r_load_n;
    assign weight_loader_Index_Out     = r_index;
    assign weight_loader_Busy_OutHigh  = r_busy;
    assign weight_loader_Done_OutHigh  = r_done;

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: a 9-register build with an attached register bank,
// plus a 1-register build.
module tb_weight_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst    = 1'b0;
    logic       start  = 1'b0;
    logic       abort  = 1'b0;
    logic       valid  = 1'b0;
    logic [7:0] din    = 8'h00;
    logic       ready;
    logic [7:0] dout;
    logic [8:0] load_n;
    logic [3:0] index;
    logic       busy;
    logic       done;

    logic       start1 = 1'b0;
    logic       abort1 = 1'b0;
    logic       valid1 = 1'b0;
    logic [7:0] din1   = 8'h00;
    logic       ready1;
    logic [7:0] dout1;
    logic [0:0] load1;
    logic [0:0] index1;
    logic       busy1;
    logic       done1;

    weight_loader #(.DATAWIDTH_BUS(8), .NUM_REGS(9), .CNT_WIDTH(4)) u_dut (
        .weight_loader_CLOCK        (clk),
        .weight_loader_Reset_InHigh (rst),
        .weight_loader_Start_InHigh (start),
        .weight_loader_Abort_InHigh (abort),
        .weight_loader_DataInBUS    (din),
        .weight_loader_Valid_InHigh (valid),
        .weight_loader_Ready_OutHigh(ready),
        .weight_loader_DataOutBUS   (dout),
        .weight_loader_Load_OutLow  (load_n),
        .weight_loader_Index_Out    (index),
        .weight_loader_Busy_OutHigh (busy),
        .weight_loader_Done_OutHigh (done)
    );

    weight_loader #(.DATAWIDTH_BUS(8), .NUM_REGS(1), .CNT_WIDTH(1)) u_dut1 (
        .weight_loader_CLOCK        (clk),
        .weight_loader_Reset_InHigh (rst),
        .weight_loader_Start_InHigh (start1),
        .weight_loader_Abort_InHigh (abort1),
        .weight_loader_DataInBUS    (din1),
        .weight_loader_Valid_InHigh (valid1),
        .weight_loader_Ready_OutHigh(ready1),
        .weight_loader_DataOutBUS   (dout1),
        .weight_loader_Load_OutLow  (load1),
        .weight_loader_Index_Out    (index1),
        .weight_loader_Busy_OutHigh (busy1),
        .weight_loader_Done_OutHigh (done1)
    );

    // Behavioural register bank downstream of the loader.
    logic       bank_clr = 1'b0;
    logic [7:0] bank [9];
    always @(posedge clk) begin
        for (int i = 0; i < 9; i++) begin
            if (bank_clr) bank[i] <= 8'h00;
            else if (load_n[i] === 1'b0) bank[i] <= dout;
        end
    end

    typedef struct packed {
        logic       is_done;
        logic [3:0] idx;
        logic [7:0] data;
    } ev_t;
    ev_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe or done pulse must match the next expected event.
    initial begin
        ev_t        e;
        logic [8:0] ep;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && (load_n !== 9'h1FF || done !== 1'b0)) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_output", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_done) begin
                        chk("sb_done_strobes_idle", 32'(load_n), 32'h1FF);
                        chk("sb_done_pulse", 32'(done), 32'd1);
                    end else begin
                        ep = ~(9'd1 << e.idx);
                        chk("sb_strobe", 32'(load_n), 32'(ep));
                        chk("sb_data", 32'(dout), 32'(e.data));
                        chk("sb_no_done", 32'(done), 32'd0);
                    end
                end
            end
        end
    end

    logic [7:0] W1 [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    logic [7:0] W3 [9] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
    logic [3:0] m_idx = 4'd0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_idx = 4'd0;
        chk("start_ready", 32'(ready), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_index", 32'(index), 32'd0);
    endtask

    task automatic beat(input logic [7:0] d, input bit last);
        ev_t e;
        din   = d;
        valid = 1'b1;
        e.is_done = 1'b0;
        e.idx     = m_idx;
        e.data    = d;
        exp_q.push_back(e);
        if (last) begin
            e.is_done = 1'b1;
            exp_q.push_back(e);
        end
        tick();
        valid = 1'b0;
        m_idx = m_idx + 4'd1;
    endtask

    task automatic stall;
        din   = 8'hEE;
        valid = 1'b0;
        tick();
    endtask

    task automatic finish_checks(input string tag);
        chk({tag, "_flush_busy"}, 32'(busy), 32'd1);
        chk({tag, "_flush_ready"}, 32'(ready), 32'd0);
        chk({tag, "_flush_index"}, 32'(index), 32'd9);
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_index"}, 32'(index), 32'd9);
        tick();
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        chk("rst_load", 32'(load_n), 32'h1FF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_index", 32'(index), 32'd0);
        bank_clr = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bank_clr = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_load", 32'(load_n), 32'h1FF);
        chk("post_rst_ready", 32'(ready), 32'd0);

        // Continuous load, Valid held high.
        start_seq();
        for (int i = 0; i < 9; i++) beat(W1[i], i == 8);
        finish_checks("cont");
        for (int i = 0; i < 9; i++) chk($sformatf("cont_bank%0d", i), 32'(bank[i]), 32'(W1[i]));

        // Stalls: Valid pattern 1,0,0,1,0,0,...
        bank_clr = 1'b1;
        tick();
        bank_clr = 1'b0;
        start_seq();
        for (int i = 0; i < 9; i++) begin
            beat(W1[i], i == 8);
            if (i != 8) begin
                stall();
                stall();
                chk($sformatf("stall_index%0d", i), 32'(index), 32'(i + 1));
            end
        end
        finish_checks("stall");
        for (int i = 0; i < 9; i++) chk($sformatf("stall_bank%0d", i), 32'(bank[i]), 32'(W1[i]));

        // Abort at Index=4 together with a beat.
        start_seq();
        for (int i = 0; i < 4; i++) beat(W3[i], 1'b0);
        din   = W3[4];
        valid = 1'b1;
        abort = 1'b1;
        tick();
        valid = 1'b0;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_index", 32'(index), 32'd4);
        chk("abort_load", 32'(load_n), 32'h1FF);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        tick();
        chk("abort_no_done_later", 32'(done), 32'd0);
        for (int i = 0; i < 9; i++)
            chk($sformatf("abort_bank%0d", i), 32'(bank[i]), 32'(i < 4 ? W3[i] : W1[i]));

        // Start while busy is ignored; then reset mid-sequence at Index=6.
        start_seq();
        for (int i = 0; i < 3; i++) beat(W1[i], 1'b0);
        start = 1'b1;
        valid = 1'b0;
        tick();
        start = 1'b0;
        chk("busy_start_index", 32'(index), 32'd3);
        chk("busy_start_busy", 32'(busy), 32'd1);
        chk("busy_start_ready", 32'(ready), 32'd1);
        for (int i = 3; i < 6; i++) beat(W1[i], 1'b0);
        stall();
        chk("mid_index6", 32'(index), 32'd6);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_load", 32'(load_n), 32'h1FF);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_index", 32'(index), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_post_busy", 32'(busy), 32'd0);
        chk("mid_post_load", 32'(load_n), 32'h1FF);

        // Single-register build.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1_ready", 32'(ready1), 32'd1);
        chk("n1_busy", 32'(busy1), 32'd1);
        din1   = 8'hA5;
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        chk("n1_strobe", 32'(load1), 32'd0);
        chk("n1_dout", 32'(dout1), 32'hA5);
        chk("n1_flush_busy", 32'(busy1), 32'd1);
        chk("n1_flush_ready", 32'(ready1), 32'd0);
        chk("n1_index", 32'(index1), 32'd1);
        tick();
        chk("n1_strobe_release", 32'(load1), 32'd1);
        chk("n1_done", 32'(done1), 32'd1);
        chk("n1_busy_drop", 32'(busy1), 32'd0);
        tick();
        chk("n1_done_one_cycle", 32'(done1), 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
